// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the cache arbiter slice.
package arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } arb_grant_e;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of icache, dcache and physical-memory signals around the arbiter.
//
// Handshake: a requester raises its read/write strobe together with its
// address (and write data) and holds them until it sees its single-cycle
// resp pulse; rdata is only meaningful (and only non-zero) while resp is 1.
// The pmem side follows the same rule: pmem_read/pmem_write stay asserted
// with stable address/data until the adaptor pulses pmem_resp for one cycle.
interface cache_arbiter_if import arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
);

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // Arbiter side.
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  // Environment side (caches plus cacheline adaptor).
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter_select.sv
// Combinational winner select: req[0] is icache, req[1] is dcache.
// prio_d chooses the winner only when both request at once.
module arb_select import arb_pkg::*; (
  input  logic [1:0] req,
  input  logic       prio_d,
  output arb_grant_e grant
);

  // Single requester wins outright; a tie is broken by prio_d.
  always_comb begin
    grant = GNT_NONE;
    case (req)
      2'b01:   grant = GNT_I;
      2'b10:   grant = GNT_D;
      2'b11:   grant = prio_d ? GNT_D : GNT_I;
      default: grant = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Two-client (icache/dcache) arbiter in front of a single cacheline adaptor.
// Optional feature: define ARB_ROUND_ROBIN_EN to replace fixed dcache
// priority with round-robin arbitration on simultaneous requests.
module cache_arbiter import arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus,
  output arb_state_e      dbg_state
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [LINE_W-1:0] LINE_ZERO = '0;

  arb_state_e state;
  arb_grant_e grant;
  logic       d_wr_q;
  logic       prio_d;
  logic [1:0] req;
  logic       serve_i;
  logic       serve_d;

  assign req = {bus.d_read | bus.d_write, bus.i_read};

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;  // 1: dcache wins the next tie

  // Favour whichever side was not just served; updated on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= 1'b1;
    end else if ((state == SERVE_I || state == SERVE_D) && bus.pmem_resp) begin
      rr_ptr <= (state == SERVE_I);
    end
  end

  assign prio_d = rr_ptr;
`else
  assign prio_d = 1'b1;
`endif

  arb_select u_select (
    .req    (req),
    .prio_d (prio_d),
    .grant  (grant)
  );

  // Grant FSM; the dcache op is latched so a dropped request still finishes
  // the transfer it started, and read+write together is taken as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      d_wr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          case (grant)
            GNT_I: state <= SERVE_I;
            GNT_D: begin
              state  <= SERVE_D;
              d_wr_q <= bus.d_write;
            end
            default: state <= IDLE;
          endcase
        end
        SERVE_I, SERVE_D: if (bus.pmem_resp) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign serve_i   = (state == SERVE_I);
  assign serve_d   = (state == SERVE_D);
  assign dbg_state = state;

  // Only the granted side reaches pmem; everything is zero outside SERVE.
  assign bus.pmem_read  = serve_i | (serve_d & ~d_wr_q);
  assign bus.pmem_write = serve_d & d_wr_q;
  assign bus.pmem_addr  = serve_i ? bus.i_addr : (serve_d ? bus.d_addr : ADDR_ZERO);
  assign bus.pmem_wdata = serve_d ? bus.d_wdata : LINE_ZERO;

  // Completion passes straight through to the granted requester only.
  assign bus.i_resp  = serve_i & bus.pmem_resp;
  assign bus.d_resp  = serve_d & bus.pmem_resp;
  assign bus.i_rdata = bus.i_resp ? bus.pmem_rdata : LINE_ZERO;
  assign bus.d_rdata = bus.d_resp ? bus.pmem_rdata : LINE_ZERO;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed cases plus randomized request mixes,
// checked against a transaction-level model of the arbitration rules.
module tb_cache_arbiter;
  import arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef struct {
    bit                is_d;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } xfer_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus();
  arb_state_e dbg_state;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  xfer_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    favour_d = 1'b1;  // model: side that wins the next tie

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_pmem_read"},  bus.pmem_read,  0);
    check({tag, "_pmem_write"}, bus.pmem_write, 0);
    check({tag, "_pmem_addr"},  bus.pmem_addr,  0);
    check({tag, "_pmem_wdata"}, bus.pmem_wdata, 0);
    check({tag, "_i_resp"},     bus.i_resp,     0);
    check({tag, "_d_resp"},     bus.d_resp,     0);
    check({tag, "_i_rdata"},    bus.i_rdata,    0);
    check({tag, "_d_rdata"},    bus.d_rdata,    0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic init_inputs();
    bus.i_read = 0; bus.i_addr = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 0;
  endtask

  // One request episode. Model: a lone request is served from the next
  // cycle; on a tie the favoured side goes first (always dcache without
  // round-robin); each transfer holds until pmem_resp, then two quiet cycles
  // (DONE, IDLE) pass before the next transfer may start.
  task automatic run_scenario(input bit use_i, input bit use_d, input bit d_wr, input bit d_rd,
                              input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                              input logic [LINE_W-1:0] dw, input int fix_lat,
                              input bit fix_rd_en, input logic [LINE_W-1:0] fix_rd,
                              input bit drop_own);
    xfer_t xi, xd, cur;
    bit first_d, busy, resp, drop_next, finished;
    int next_start, lat, lat_cnt, served, n, end_at;
    logic [LINE_W-1:0] rd;
    xi.is_d = 0; xi.wr = 0;    xi.addr = ia; xi.wdata = '0;
    xd.is_d = 1; xd.wr = d_wr; xd.addr = da; xd.wdata = dw;
    exp_q.delete();
    if (use_i && use_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      first_d = favour_d;
`else
      first_d = 1'b1;
`endif
      if (first_d) begin exp_q.push_back(xd); exp_q.push_back(xi); end
      else begin exp_q.push_back(xi); exp_q.push_back(xd); end
    end else if (use_i) exp_q.push_back(xi);
    else exp_q.push_back(xd);
    n = exp_q.size();
    busy = 0; resp = 0; drop_next = 0; finished = 0; served = 0;
    next_start = 1; end_at = -1; lat = 1; lat_cnt = 0; rd = '0; cur = xi;

    for (int t = 0; t < 200 && !finished; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        bus.i_read = use_i; bus.i_addr = ia;
        bus.d_read = use_d & d_rd; bus.d_write = use_d & d_wr;
        bus.d_addr = da; bus.d_wdata = dw;
      end
      if (drop_next) begin
        if (cur.is_d) begin bus.d_read = 0; bus.d_write = 0; end
        else bus.i_read = 0;
        drop_next = 0;
      end
      if (!busy && served < n && t == next_start) begin
        busy = 1; cur = exp_q[0]; lat_cnt = 0;
        lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 4));
        rd = fix_rd_en ? fix_rd : rand_line();
      end
      resp = 0;
      if (busy) begin
        lat_cnt++;
        resp = (lat_cnt == lat);
        if (drop_own && lat_cnt == 2 && !resp) begin
          if (cur.is_d) begin bus.d_read = 0; bus.d_write = 0; end
          else bus.i_read = 0;
        end
      end
      bus.pmem_resp  = resp;
      bus.pmem_rdata = resp ? rd : rand_line();
      #1;
      check("rw_exclusive", bus.pmem_read & bus.pmem_write, 0);
      if (busy) begin
        check("pmem_read",  bus.pmem_read,  !(cur.is_d && cur.wr));
        check("pmem_write", bus.pmem_write, cur.is_d && cur.wr);
        check("pmem_addr",  bus.pmem_addr,  cur.addr);
        if (cur.is_d && cur.wr) check("pmem_wdata", bus.pmem_wdata, cur.wdata);
        check("i_resp",  bus.i_resp,  resp && !cur.is_d);
        check("d_resp",  bus.d_resp,  resp && cur.is_d);
        check("i_rdata", bus.i_rdata, (resp && !cur.is_d) ? rd : '0);
        check("d_rdata", bus.d_rdata, (resp && cur.is_d) ? rd : '0);
        if (resp) begin
          cur = exp_q.pop_front();
          served++; busy = 0; favour_d = !cur.is_d; drop_next = 1;
          next_start = t + 3;
          if (served == n) end_at = t + 2;
        end
      end else begin
        check("pmem_quiet", {bus.pmem_read, bus.pmem_write}, 0);
        check("resp_quiet", {bus.i_resp, bus.d_resp}, 0);
        check("rdata_quiet", bus.i_rdata | bus.d_rdata, 0);
        if (t == end_at) finished = 1;
      end
    end
    if (!finished) check("scenario_timeout", 0, 1);
    init_inputs();
  endtask

  // Reset pulled mid-way through a dcache read: outputs drop at once,
  // no resp follows, and the model pointer returns to favouring dcache.
  task automatic reset_mid_serve();
    @(posedge clk); #1;
    bus.d_read = 1; bus.d_addr = 32'h200; bus.d_wdata = rand_line();
    @(posedge clk); #1;
    check("rst_pre_read", bus.pmem_read, 1);
    check("rst_pre_addr", bus.pmem_addr, 32'h200);
    #2;
    rst = 0;
    bus.pmem_resp = 1; bus.pmem_rdata = rand_line();
    #1;
    check_all_zero("rst_mid");
    bus.d_read = 0; bus.pmem_resp = 0;
    repeat (2) @(negedge clk);
    check_all_zero("rst_hold");
    rst = 1;
    favour_d = 1'b1;
    repeat (2) begin
      @(posedge clk); #2;
      check("rst_after_state", dbg_state, IDLE);
      check("rst_after_resp", {bus.i_resp, bus.d_resp}, 0);
      check("rst_after_pmem", {bus.pmem_read, bus.pmem_write}, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ui, ud, wr, rdop, dropf;
    int op, sel;
    init_inputs();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1;
    @(posedge clk); #2;
    check("reset_state", dbg_state, IDLE);

    run_scenario(1, 0, 0, 0, 32'h60, 32'h0, '0, 3, 1, {32{8'hA5}}, 0);
    run_scenario(1, 1, 0, 1, 32'h100, 32'h200, rand_line(), 0, 0, '0, 0);
    run_scenario(1, 1, 0, 1, 32'h100, 32'h200, rand_line(), 0, 0, '0, 0);
    run_scenario(0, 1, 1, 0, 32'h0, 32'h3C0, {8{32'hDEAD_BEEF}}, 2, 0, '0, 0);
    reset_mid_serve();
    run_scenario(1, 0, 0, 0, 32'h40, 32'h0, '0, 0, 0, '0, 0);

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(1, 3);
      ui = sel[0]; ud = sel[1];
      op = $urandom_range(0, 2);
      wr   = (op != 0);
      rdop = (op != 1);
      dropf = ($urandom_range(0, 3) == 0);
      run_scenario(ui, ud, wr, rdop, $urandom() & 32'hFFFF_FFE0, $urandom() & 32'hFFFF_FFE0,
                   rand_line(), 0, 0, '0, dropf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
